if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000: instruction word injected into IF/ID on flush or bubble.
REQ-003 clk  input  1  main clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 en  input  1  CPU enable from the debug control; 0 freezes all state.
REQ-006 stall  input  1  hazard hold; PC and IF/ID keep their values.
REQ-007 redirect  input  1  taken branch, jump or jr resolved downstream.
REQ-008 redirect_pc  input  32  target address for redirect.
REQ-009 imem_addr  output  32  instruction memory address, equal to the current PC.
REQ-010 imem_data  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-011 id_inst  output  32  IF/ID instruction word, fed to the decode controller.
REQ-012 id_pc  output  32  PC of id_inst.
REQ-013 id_pc_plus4  output  32  id_pc + 4, used for link and branch base.
REQ-014 id_valid  output  1  id_inst is a real fetched instruction, not a bubble.
REQ-015 fetch_count  output  32  number of valid instructions latched into IF/ID since reset.

Function
REQ-016 imem_addr SHALL be driven combinationally from the PC register, with zero added latency.
REQ-017 Update priority per posedge SHALL be: rst > ~en > redirect > stall > normal.
REQ-018 en=0: PC, IF/ID and fetch_count SHALL hold, regardless of redirect or stall.
REQ-019 Normal (en=1, redirect=0, stall=0): PC<=PC+4; id_inst<=imem_data, id_pc<=PC, id_pc_plus4<=PC+4, id_valid<=1, fetch_count+=1.
REQ-020 Redirect (en=1, redirect=1): PC<={redirect_pc[31:2],2'b00}; id_inst<=NOP_INST, id_valid<=0; id_pc and id_pc_plus4 hold; fetch_count holds; stall is ignored.
REQ-021 Stall only (en=1, redirect=0, stall=1): PC, IF/ID and fetch_count SHALL hold.
REQ-022 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag raised.
REQ-023 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-024 Fetch latency: the word at address A SHALL appear on id_inst one cycle after imem_addr=A when not stalled.
REQ-025 The PC register SHALL keep bits [1:0] at 2'b00 at all times.

Reset
REQ-026 On rst=1 at posedge: PC<=RESET_PC, id_inst<=NOP_INST, id_pc<=0, id_pc_plus4<=0, id_valid<=0, fetch_count<=0.
REQ-027 rst SHALL override en, stall and redirect, including mid-stall and mid-redirect.
REQ-028 The first cycle after rst falls SHALL present imem_addr=RESET_PC.

Structure
REQ-029 RESET_PC default, NOP_INST and the PC increment constant SHALL live in the shared MIPS define package used by the decode controller.
REQ-030 The IF/ID register (inst/pc/pc_plus4/valid with hold and flush inputs) SHALL be one sub-module, if_id_reg; the PC register and next-PC mux stay in if_stage.

Verification
REQ-031 Reset then 3 free cycles, imem returns 0x20080001/0x20090002/0x01095020 -> id_pc 0,4,8; id_valid=1; fetch_count=3.
REQ-032 Stall=1 for 2 cycles at PC=0x8 -> imem_addr stays 0x8; id_inst/fetch_count unchanged; resumes at 0xC.
REQ-033 redirect=1, redirect_pc=0x40, stall=1 in the same cycle -> next PC=0x40; id_inst=0; id_valid=0; fetch_count unchanged.
REQ-034 en=0 for 3 cycles with redirect=1 -> PC and IF/ID frozen; on en=1 the redirect takes effect.
REQ-035 redirect_pc=0xFFFF_FFFE -> PC=0xFFFF_FFFC; next normal cycle PC=0x0, id_pc=0xFFFF_FFFC.
REQ-036 rst asserted during stall at PC=0x20 -> PC=RESET_PC, id_valid=0, fetch_count=0 on the next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared MIPS definitions used by the fetch stage and the decode controller:
// reset PC, NOP encoding, PC increment, the IF/ID record and PC alignment.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] MIPS_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] MIPS_NOP_INST   = 32'h0000_0000;
  localparam logic [XLEN-1:0] MIPS_PC_INCR    = 32'h0000_0004;
  localparam logic [XLEN-1:0] MIPS_PC_ALIGN_M = 32'hFFFF_FFFC;

  // Which update the fetch stage performs on the coming clock edge, in priority order.
  typedef enum logic [2:0] {
    UPD_RESET    = 3'd0,
    UPD_HOLD     = 3'd1,
    UPD_REDIRECT = 3'd2,
    UPD_STALL    = 3'd3,
    UPD_NORMAL   = 3'd4
  } if_upd_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & MIPS_PC_ALIGN_M;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes everything, flush injects a bubble
// while keeping the PC fields, otherwise the fetched record is latched.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = MIPS_NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_hold,
  input  logic   i_flush,
  input  if_id_t i_data,
  output if_id_t o_data
);

  if_id_t r_data;
  if_id_t w_data_next;

  always_comb begin
    w_data_next = r_data;
    if (i_hold) begin
      w_data_next = r_data;
    end else if (i_flush) begin
      // pc/pc_plus4 stay put so the bubble still carries its last address
      w_data_next.inst  = NOP_INST;
      w_data_next.valid = 1'b0;
    end else begin
      w_data_next = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data.inst     <= NOP_INST;
      r_data.pc       <= '0;
      r_data.pc_plus4 <= '0;
      r_data.valid    <= 1'b0;
    end else begin
      r_data <= w_data_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with next-PC mux, instruction memory
// address, IF/ID register and a count of valid fetches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INST = MIPS_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_fetch_count_next;
  if_upd_e     w_upd;
  logic        w_hold;
  logic        w_flush;
  if_id_t      w_if_data;
  if_id_t      w_id_data;

  always_comb begin
    w_upd = UPD_NORMAL;
    if (rst) begin
      w_upd = UPD_RESET;
    end else if (!en) begin
      w_upd = UPD_HOLD;
    end else if (redirect) begin
      w_upd = UPD_REDIRECT;
    end else if (stall) begin
      w_upd = UPD_STALL;
    end
  end

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps silently to 0.
  assign w_pc_plus4 = r_pc + MIPS_PC_INCR;

  always_comb begin
    w_pc_next          = r_pc;
    w_fetch_count_next = r_fetch_count;
    case (w_upd)
      UPD_RESET: begin
        w_pc_next          = align_pc(RESET_PC);
        w_fetch_count_next = '0;
      end
      UPD_REDIRECT: begin
        w_pc_next = align_pc(redirect_pc);
      end
      UPD_NORMAL: begin
        w_pc_next          = align_pc(w_pc_plus4);
        w_fetch_count_next = r_fetch_count + 32'd1;
      end
      default: begin
        w_pc_next          = r_pc;
        w_fetch_count_next = r_fetch_count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= align_pc(RESET_PC);
      r_fetch_count <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign w_hold  = (w_upd == UPD_HOLD) || (w_upd == UPD_STALL);
  assign w_flush = (w_upd == UPD_REDIRECT);

  assign w_if_data.inst     = imem_data;
  assign w_if_data.pc       = r_pc;
  assign w_if_data.pc_plus4 = w_pc_plus4;
  assign w_if_data.valid    = 1'b1;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .i_hold (w_hold),
    .i_flush(w_flush),
    .i_data (w_if_data),
    .o_data (w_id_data)
  );

  assign imem_addr   = r_pc;
  assign id_inst     = w_id_data.inst;
  assign id_pc       = w_id_data.pc;
  assign id_pc_plus4 = w_id_data.pc_plus4;
  assign id_valid    = w_id_data.valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a driver applies hand-computed vectors and
// queues the expected post-edge state; a monitor pops and compares it.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int EXP_W = 32 * 5 + 1;

  // clock / reset block
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_valid   (id_valid),
    .fetch_count(fetch_count)
  );

  // scoreboard: {pc, inst, id_pc, id_pc_plus4, fetch_count, valid}
  logic [EXP_W-1:0] exp_q[$];
  string            tag_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: one expected record per clock edge the driver issued
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      string            t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".imem_addr"},   imem_addr,           e[160:129]);
      check({t, ".id_inst"},     id_inst,             e[128:97]);
      check({t, ".id_pc"},       id_pc,               e[96:65]);
      check({t, ".id_pc_plus4"}, id_pc_plus4,         e[64:33]);
      check({t, ".fetch_count"}, fetch_count,         e[32:1]);
      check({t, ".id_valid"},    {31'd0, id_valid},   {31'd0, e[0]});
    end
  end

  // driver: apply inputs at negedge, queue the state expected after the next posedge
  task automatic step(input string tag,
                      input logic r, input logic e, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic [31:0] data,
                      input logic [31:0] x_pc, input logic [31:0] x_inst,
                      input logic [31:0] x_ipc, input logic [31:0] x_ip4,
                      input logic x_v, input logic [31:0] x_cnt);
    @(negedge clk);
    rst         = r;
    en          = e;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_data   = data;
    exp_q.push_back({x_pc, x_inst, x_ipc, x_ip4, x_cnt, x_v});
    tag_q.push_back(tag);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_data = '0;
    //         tag        rst en st rd redirect_pc    imem_data      pc             inst           id_pc          id_pc+4        v  count
    step("reset0",        1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    step("free1",         0, 1, 0, 0, 32'h0,        32'h20080001, 32'h4,        32'h20080001, 32'h0,        32'h4,        1, 1);
    step("free2",         0, 1, 0, 0, 32'h0,        32'h20090002, 32'h8,        32'h20090002, 32'h4,        32'h8,        1, 2);
    step("free3",         0, 1, 0, 0, 32'h0,        32'h01095020, 32'hC,        32'h01095020, 32'h8,        32'hC,        1, 3);
    step("reset1",        1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    step("run1",          0, 1, 0, 0, 32'h0,        32'h11111111, 32'h4,        32'h11111111, 32'h0,        32'h4,        1, 1);
    step("run2",          0, 1, 0, 0, 32'h0,        32'h22222222, 32'h8,        32'h22222222, 32'h4,        32'h8,        1, 2);
    step("stall1",        0, 1, 1, 0, 32'h0,        32'h33333333, 32'h8,        32'h22222222, 32'h4,        32'h8,        1, 2);
    step("stall2",        0, 1, 1, 0, 32'h0,        32'h33333333, 32'h8,        32'h22222222, 32'h4,        32'h8,        1, 2);
    step("resume",        0, 1, 0, 0, 32'h0,        32'h33333333, 32'hC,        32'h33333333, 32'h8,        32'hC,        1, 3);
    step("redir_stall",   0, 1, 1, 1, 32'h40,       32'h99999999, 32'h40,       32'h0,        32'h8,        32'hC,        0, 3);
    step("after_redir",   0, 1, 0, 0, 32'h0,        32'h44444444, 32'h44,       32'h44444444, 32'h40,       32'h44,       1, 4);
    step("en0_a",         0, 0, 0, 1, 32'h80,       32'h55555555, 32'h44,       32'h44444444, 32'h40,       32'h44,       1, 4);
    step("en0_b",         0, 0, 1, 1, 32'h80,       32'h55555555, 32'h44,       32'h44444444, 32'h40,       32'h44,       1, 4);
    step("en0_c",         0, 0, 0, 1, 32'h80,       32'h55555555, 32'h44,       32'h44444444, 32'h40,       32'h44,       1, 4);
    step("en1_redir",     0, 1, 0, 1, 32'h80,       32'h55555555, 32'h80,       32'h0,        32'h40,       32'h44,       0, 4);
    step("redir_unalign", 0, 1, 0, 1, 32'hFFFFFFFE, 32'h55555555, 32'hFFFFFFFC, 32'h0,        32'h40,       32'h44,       0, 4);
    step("pc_wrap",       0, 1, 0, 0, 32'h0,        32'h55555555, 32'h0,        32'h55555555, 32'hFFFFFFFC, 32'h0,        1, 5);
    step("post_wrap",     0, 1, 0, 0, 32'h0,        32'h66666666, 32'h4,        32'h66666666, 32'h0,        32'h4,        1, 6);
    step("redir_20",      0, 1, 0, 1, 32'h20,       32'h66666666, 32'h20,       32'h0,        32'h0,        32'h4,        0, 6);
    step("stall_20",      0, 1, 1, 0, 32'h0,        32'h77777777, 32'h20,       32'h0,        32'h0,        32'h4,        0, 6);
    step("rst_mid_stall", 1, 1, 1, 1, 32'h100,      32'h77777777, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    step("rst_en0",       1, 0, 0, 0, 32'h0,        32'h77777777, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    step("first_fetch",   0, 1, 0, 0, 32'h0,        32'h77777777, 32'h4,        32'h77777777, 32'h0,        32'h4,        1, 1);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
